// File: rtl/data_ram_resp_pkg.sv
// data_ram_resp_pkg: shared widths, lane mapping and FSM encoding for the data RAM.
package data_ram_resp_pkg;
    localparam int RegBus = 32;
    localparam logic ChipEnable = 1'b1;
    localparam logic WriteEnable = 1'b1;
    localparam int LANES = 4;
    localparam int LANE_W = 8;
    typedef enum logic {CLEAR = 1'b0, READY = 1'b1} state_t;
    function automatic int lane_lsb(input int k);
        return k * LANE_W;
    endfunction
endpackage

// File: rtl/data_ram_resp_if.sv
// data_ram_resp_if: core-side data-RAM port (ce/we/sel/addr/write data/read data).
interface data_ram_resp_if;
    import data_ram_resp_pkg::*;
    logic ce;
    logic we;
    logic [RegBus-1:0] addr;
    logic [LANES-1:0] sel;
    logic [RegBus-1:0] data_i;
    logic [RegBus-1:0] data_o;
    modport master (output ce, we, addr, sel, data_i, input data_o);
    modport slave (input ce, we, addr, sel, data_i, output data_o);
endinterface

// File: rtl/data_ram_resp_bank.sv
// data_ram_bank: one byte lane of storage with async read; holds a parity bit under DATA_RAM_PARITY_EN.
module data_ram_bank
    import data_ram_resp_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [LANE_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [LANE_W-1:0] rdata
`ifdef DATA_RAM_PARITY_EN
    ,
    input  logic              wpar,
    output logic              rpar
`endif
);
`ifdef DATA_RAM_PARITY_EN
    logic [LANE_W:0] mem [2**ADDR_W];
    always_ff @(posedge clk)
        if (we) mem[waddr] <= {wpar, wdata};
    assign {rpar, rdata} = mem[raddr];
`else
    logic [LANE_W-1:0] mem [2**ADDR_W];
    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;
    assign rdata = mem[raddr];
`endif
endmodule

// File: rtl/data_ram_resp.sv
// data_ram_resp: word data RAM with post-reset clear sweep, sticky range flag and saturating counters.
// Optional per-lane parity with fault injection when DATA_RAM_PARITY_EN is defined.
module data_ram_resp
    import data_ram_resp_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    data_ram_resp_if.slave   bus,
    output logic             busy_o,
    output logic             range_err_o,
    output logic [CNT_W-1:0] rd_cnt_o,
    output logic [CNT_W-1:0] wr_cnt_o
`ifdef DATA_RAM_PARITY_EN
    ,
    input  logic [LANES-1:0] par_flip_i,
    output logic             parity_err_o
`endif
);
    state_t state;
    logic [ADDR_W-1:0] ptr, idx, waddr;
    logic ready, in_range, acc, wr, rd;
    logic [LANES-1:0] lane_we;
    logic [RegBus-1:0] wdata, rdata;
    logic unused;
    assign unused = ^bus.addr[1:0];
    assign ready = state == READY;
    assign idx = bus.addr[ADDR_W+1:2];
    assign in_range = bus.addr[RegBus-1:ADDR_W+2] == '0;
    assign acc = ready && bus.ce == ChipEnable;
    assign wr = acc && in_range && bus.we == WriteEnable;
    assign rd = acc && in_range && bus.we != WriteEnable;
    // the sweep borrows the write port: all lanes, pointer address, zero data
    assign waddr = ready ? idx : ptr;
    assign wdata = ready ? bus.data_i : '0;
    assign lane_we = ready ? (wr ? bus.sel : '0) : '1;
    assign bus.data_o = rd ? rdata : '0;
    assign busy_o = !ready;
`ifdef DATA_RAM_PARITY_EN
    logic [LANES-1:0] wpar, rpar, rdata_par;
`endif
    for (genvar k = 0; k < LANES; k++) begin : g_lane
`ifdef DATA_RAM_PARITY_EN
        assign wpar[k] = ready ? ^wdata[lane_lsb(k) +: LANE_W] ^ par_flip_i[k] : 1'b0;
        assign rdata_par[k] = ^rdata[lane_lsb(k) +: LANE_W];
`endif
        data_ram_bank #(.ADDR_W(ADDR_W)) u_bank (
            .clk   (clk),
            .we    (lane_we[k]),
            .waddr (waddr),
            .wdata (wdata[lane_lsb(k) +: LANE_W]),
            .raddr (idx),
            .rdata (rdata[lane_lsb(k) +: LANE_W])
`ifdef DATA_RAM_PARITY_EN
            ,
            .wpar  (wpar[k]),
            .rpar  (rpar[k])
`endif
        );
    end
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state <= CLEAR;
            ptr <= '0;
        end else if (state == CLEAR) begin
            ptr <= ptr + ADDR_W'(1);
            state <= ptr == '1 ? READY : CLEAR;
        end
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            range_err_o <= 1'b0;
            rd_cnt_o <= '0;
            wr_cnt_o <= '0;
        end else if (acc) begin
            range_err_o <= range_err_o || !in_range;
            if (bus.we != WriteEnable && rd_cnt_o != '1) rd_cnt_o <= rd_cnt_o + CNT_W'(1);
            if (bus.we == WriteEnable && wr_cnt_o != '1) wr_cnt_o <= wr_cnt_o + CNT_W'(1);
        end
`ifdef DATA_RAM_PARITY_EN
    always_ff @(posedge clk or negedge rst)
        if (!rst) parity_err_o <= 1'b0;
        else if (rd && rpar != rdata_par) parity_err_o <= 1'b1;
`endif
endmodule

// File: tb/tb_data_ram_resp.sv
// tb_data_ram_resp: directed table, random traffic against a word-array model, sweep/reset corner cases.
module tb_data_ram_resp;
    localparam int AW = 4;
    localparam int CW = 4;
    localparam int DEPTH = 2 ** AW;
    localparam int CMAX = 2 ** CW - 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic busy, rerr;
    logic [CW-1:0] rd_cnt, wr_cnt;
    int checks = 0, failures = 0;

    logic [31:0] m_mem [DEPTH];
    int m_rd, m_wr;
    bit m_rerr;

    data_ram_resp_if bus();
`ifdef DATA_RAM_PARITY_EN
    logic [3:0] par_flip = 4'b0;
    logic perr;
`endif

    data_ram_resp #(.ADDR_W(AW), .CNT_W(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .busy_o      (busy),
        .range_err_o (rerr),
        .rd_cnt_o    (rd_cnt),
        .wr_cnt_o    (wr_cnt)
`ifdef DATA_RAM_PARITY_EN
        ,
        .par_flip_i  (par_flip),
        .parity_err_o(perr)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0;
        m_rd = 0;
        m_wr = 0;
        m_rerr = 0;
    endtask

    task automatic chk_status();
        chk("rd_cnt", {28'h0, rd_cnt}, (m_rd > CMAX) ? CMAX : m_rd);
        chk("wr_cnt", {28'h0, wr_cnt}, (m_wr > CMAX) ? CMAX : m_wr);
        chk("range_err", {31'h0, rerr}, {31'h0, m_rerr});
    endtask

    // called just after a rising edge; returns sampled data_o and the model's read value
    task automatic step(input logic c, input logic w, input logic [31:0] a, input logic [3:0] s,
                        input logic [31:0] d, output logic [31:0] got, output logic [31:0] mexp);
        bit inr;
        int i;
        inr = (a >> (AW + 2)) == 0;
        i = (a >> 2) % DEPTH;
        bus.ce = c;
        bus.we = w;
        bus.addr = a;
        bus.sel = s;
        bus.data_i = d;
        @(negedge clk);
        got = bus.data_o;
        mexp = (c && !w && inr) ? m_mem[i] : 32'h0;
        @(posedge clk);
        if (c) begin
            if (!inr) m_rerr = 1;
            else if (w) for (int k = 0; k < 4; k++) if (s[k]) m_mem[i][8*k +: 8] = d[8*k +: 8];
            if (w) m_wr++;
            else m_rd++;
        end
        #1;
        bus.ce = 1'b0;
    endtask

    // starts at a falling edge with rst just released; pokes the bus while busy
    task automatic sweep(output int cnt);
        cnt = 0;
        while (busy && cnt < 100) begin
            cnt++;
            bus.ce = 1'b1;
            bus.we = cnt[0];
            bus.addr = cnt[1] ? 32'h0000_1000 : {28'h0, cnt[3:2], 2'b00};
            bus.sel = 4'hF;
            bus.data_i = 32'hFFFF_FFFF;
            #1;
            chk("busy_data", bus.data_o, 32'h0);
            @(negedge clk);
        end
        bus.ce = 1'b0;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic we;
        logic [31:0] addr;
        logic [3:0] sel;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[10];
    logic [31:0] got, mexp;
    int cnt;

    initial begin
        vecs[0] = '{1'b1, 32'h8, 4'b1111, 32'hDEAD_BEEF, 32'h0};
        vecs[1] = '{1'b0, 32'h8, 4'b0000, 32'h0, 32'hDEAD_BEEF};
        vecs[2] = '{1'b1, 32'h8, 4'b0100, 32'h00AA_0000, 32'h0};
        vecs[3] = '{1'b0, 32'hA, 4'b1111, 32'h0, 32'hDEAA_BEEF};
        vecs[4] = '{1'b1, 32'h8, 4'b0001, 32'h0000_0011, 32'h0};
        vecs[5] = '{1'b0, 32'h8, 4'b0001, 32'h0, 32'hDEAA_BE11};
        vecs[6] = '{1'b1, 32'h8, 4'b0000, 32'hFFFF_FFFF, 32'h0};
        vecs[7] = '{1'b0, 32'h8, 4'b0000, 32'h0, 32'hDEAA_BE11};
        vecs[8] = '{1'b1, 32'h0000_1000, 4'b1111, 32'h1234_5678, 32'h0};
        vecs[9] = '{1'b0, 32'h0, 4'b1111, 32'h0, 32'h0};
        bus.ce = 1'b0;
        bus.we = 1'b0;
        bus.addr = 32'h0;
        bus.sel = 4'h0;
        bus.data_i = 32'h0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset_busy", {31'h0, busy}, 32'h1);
        chk("reset_data", bus.data_o, 32'h0);
        chk_status();
        rst = 1'b1;
        sweep(cnt);
        chk("sweep_len", cnt, DEPTH);
        chk("busy_after", {31'h0, busy}, 32'h0);
        chk_status();

        for (int v = 0; v < 10; v++) begin
            step(1'b1, vecs[v].we, vecs[v].addr, vecs[v].sel, vecs[v].data, got, mexp);
            if (!vecs[v].we) chk($sformatf("vec%0d_data", v), got, vecs[v].exp);
            chk_status();
        end
        step(1'b0, 1'b0, 32'h8, 4'hF, 32'h0, got, mexp);
        chk("ce0_data", got, 32'h0);
        step(1'b1, 1'b0, 32'h0000_1008, 4'hF, 32'h0, got, mexp);
        chk("oor_read", got, 32'h0);
        chk("range_sticky", {31'h0, rerr}, 32'h1);

`ifdef DATA_RAM_PARITY_EN
        chk("perr_clean", {31'h0, perr}, 32'h0);
        par_flip = 4'b0010;
        step(1'b1, 1'b1, 32'h10, 4'hF, 32'hCAFE_F00D, got, mexp);
        par_flip = 4'b0000;
        step(1'b1, 1'b0, 32'h10, 4'hF, 32'h0, got, mexp);
        chk("perr_set", {31'h0, perr}, 32'h1);
        step(1'b1, 1'b1, 32'h14, 4'hF, 32'h0F0F_1234, got, mexp);
        step(1'b1, 1'b0, 32'h14, 4'hF, 32'h0, got, mexp);
        chk("perr_sticky", {31'h0, perr}, 32'h1);
`endif

        for (int n = 0; n < 400; n++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 7) == 0) ? ($urandom | 32'h0000_0040)
                                            : {26'h0, 4'($urandom_range(0, DEPTH - 1)), 2'($urandom)};
            step($urandom_range(0, 5) != 0, 1'($urandom), a, 4'($urandom), $urandom, got, mexp);
            chk("rand_data", got, mexp);
            if (n % 50 == 0) chk_status();
        end
        chk_status();

        rst = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        chk("mid_busy", {31'h0, busy}, 32'h1);
        rst = 1'b0;
        @(negedge clk);
        chk_status();
        rst = 1'b1;
        sweep(cnt);
        chk("resweep_len", cnt, DEPTH);
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b0, 32'(i % DEPTH) << 2, 4'hF, 32'h0, got, mexp);
            chk("clear_word", got, 32'h0);
        end
        chk("rd_sat", {28'h0, rd_cnt}, 32'(CMAX));
        chk("wr_after_reset", {28'h0, wr_cnt}, 32'h0);
        chk("rerr_after_reset", {31'h0, rerr}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
